cdce_config_sequencer: RTL and testbench
========================================

Name: cdce_config_sequencer

Overview:
- Drives the CDCE serial shifter (32-bit command serializer: start/done handshake, enable gate).
- Walks a table of NUM_WORDS 32-bit CDCE register words in address order and issues one serializer transaction per word, with a programmable dead gap between words.
- Sits between board bring-up control (power-good / re-config request) and the serializer; the table lives in an external synchronous ROM/RAM.
- Reports busy, done and a handshake-timeout error.

Parameters:
- NUM_WORDS, 9, number of table words sent (CDCE registers 0..8); must be >= 1.
- POWERUP_CYCLES, 1000, clk cycles waited after reset before an auto-start; 0 disables auto-start.
- GAP_CYCLES, 4, idle cycles between the done of one word and the fetch of the next; 0 is legal.
- TIMEOUT_CYCLES, 255, max cycles waited in either handshake phase before error.
- EEPROM_CMD, 32'h0000_001F, extra trailing command word (optional feature only).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  request (re)configuration; level sampled in IDLE/DONE/ERROR.
- word_addr  out  $clog2(NUM_WORDS) (min 1)  table read address; registered.
- word_data  in  32  table word; valid one cycle after word_addr changes.
- ser_enable  out  1  serializer enable; 1 whenever not in reset.
- ser_start  out  1  serializer start request.
- ser_data  out  32  word to serialize; registered, stable during handshake.
- ser_done  in  1  serializer transaction_done; high when idle, low while busy.
- busy  out  1  sequence in progress.
- config_done  out  1  all words sent; held until next start.
- error  out  1  handshake timeout; held until next start.

Behaviour:
- Reset (reset_n=0 at a clk edge) puts the FSM in PWRUP. Outputs: word_addr=0, ser_start=0, ser_data=0, busy=0, config_done=0, error=0, ser_enable=0. The first cycle after reset releases ser_enable=1.
- Reset mid-transaction aborts immediately. Serializer reset is shared, so no partial word is resumed.
- States: PWRUP, IDLE, FETCH, ISSUE, WAIT_ACK, WAIT_DONE, GAP, DONE, ERROR.
- PWRUP: counts POWERUP_CYCLES, then goes to FETCH with word_addr=0. With POWERUP_CYCLES=0 it goes to IDLE next cycle.
- IDLE/DONE/ERROR: start=1 -> FETCH. On that transition: word_addr=0, config_done and error cleared.
- FETCH: one cycle. At exit, ser_data <= word_data.
- ISSUE: ser_start=1 for exactly one cycle, then WAIT_ACK.
- WAIT_ACK: ser_start held 1 until ser_done=0 is sampled, then ser_start=0 and go to WAIT_DONE.
- WAIT_DONE: ser_done=1 sampled -> GAP.
- Each of WAIT_ACK and WAIT_DONE has a timeout counter that resets on entry. Reaching TIMEOUT_CYCLES -> ERROR with ser_start=0, error=1, busy=0.
- GAP: counts GAP_CYCLES (0 = zero extra cycles). Then:
  - If word_addr == NUM_WORDS-1 -> DONE, with config_done=1 and busy=0.
  - Otherwise word_addr += 1 -> FETCH.
- word_addr never wraps; it stays at NUM_WORDS-1 in DONE.
- busy=1 in FETCH, ISSUE, WAIT_ACK, WAIT_DONE and GAP, and also in PWRUP when auto-start is active.
- start asserted while busy is ignored (not queued).
- config_done and error are never 1 simultaneously.
- Minimum per-word time: FETCH(1) + ISSUE(1) + handshake + GAP_CYCLES.
- Counter widths: $clog2(max+1). Counters compare with ==, never overflow.

Optional Feature:
- CDCE_CFG_EEPROM_EN defined:
  - After the last table word's GAP, one extra transaction sends EEPROM_CMD via the same ISSUE/WAIT_ACK/WAIT_DONE/GAP path. It is not read from the table, and word_addr stays at NUM_WORDS-1.
  - config_done rises only after that transaction completes. A timeout on it gives error.
- Not defined: sequence ends after table word NUM_WORDS-1; EEPROM_CMD is unused.

Decomposition:
- Shared package cdce_cfg_pkg holds:
  - state enum typedef (9 encodings);
  - CDCE word width constant (32);
  - default EEPROM_CMD constant.
- Sub-module cdce_cfg_timer: a loadable down-counter with a zero flag, reused for the PWRUP, GAP and timeout counts (three instances or one muxed). No other split is needed.

Test Plan:
- Auto-start: POWERUP_CYCLES=10, NUM_WORDS=3, GAP=2, model serializer (ser_done low 34 cycles). Required: first ser_start exactly 12 cycles after reset release; words 0,1,2 appear in order on ser_data; config_done=1, busy=0 at end.
- Manual start: POWERUP_CYCLES=0, pulse start in IDLE. Required: FETCH on next cycle; ser_start pulse; word_addr runs 0->2; start pulses during busy cause no restart.
- Handshake timeout: model never drops ser_done, TIMEOUT_CYCLES=8. Required: error=1 after 8 WAIT_ACK cycles, ser_start=0. A following start clears error and resends word 0.
- Stuck busy: ser_done stays low after ack. Required: error after TIMEOUT_CYCLES in WAIT_DONE, with config_done=0.
- Reset mid-word: reset_n=0 for 1 cycle during WAIT_DONE of word 1. Required: all outputs at reset values next cycle; the sequence restarts from word 0.
- Feature on: build with CDCE_CFG_EEPROM_EN and NUM_WORDS=2. Required: three transactions, the last with ser_data=32'h0000_001F; config_done rises only after it.

Source files
------------

// File: rtl/cdce_cfg_pkg.sv
// Shared types and constants for the CDCE configuration sequencer.
package cdce_cfg_pkg;

    localparam int unsigned CDCE_WORD_W = 32;
    localparam logic [CDCE_WORD_W-1:0] CDCE_EEPROM_CMD_DEFAULT = 32'h0000_001F;

    typedef enum logic [3:0] {
        ST_PWRUP,
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_GAP,
        ST_DONE,
        ST_ERROR
    } cdce_state_t;

    function automatic int unsigned cdce_max3(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cdce_cfg_timer.sv
// Loadable down-counter with zero flag; saturates at zero.
module cdce_cfg_timer
    import cdce_cfg_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= RESET_VALUE;
        end else if (load) begin
            count <= value;
        end else if (!zero) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/cdce_config_sequencer.sv
// Walks the CDCE register table and drives the serializer handshake.
// Optional trailing EEPROM-store command: define CDCE_CFG_EEPROM_EN.
module cdce_config_sequencer
    import cdce_cfg_pkg::*;
#(
    parameter int unsigned NUM_WORDS      = 9,
    parameter int unsigned POWERUP_CYCLES = 1000,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [CDCE_WORD_W-1:0] EEPROM_CMD = CDCE_EEPROM_CMD_DEFAULT,
    localparam int unsigned AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    output logic [AW-1:0]          word_addr,
    input  logic [CDCE_WORD_W-1:0] word_data,
    output logic                   ser_enable,
    output logic                   ser_start,
    output logic [CDCE_WORD_W-1:0] ser_data,
    input  logic                   ser_done,
    output logic                   busy,
    output logic                   config_done,
    output logic                   error
);

`ifdef CDCE_CFG_EEPROM_EN
    localparam bit EEPROM_EN = 1'b1;
`else
    localparam bit EEPROM_EN = 1'b0;
`endif

    localparam int unsigned CNT_MAX  = cdce_max3(POWERUP_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
    localparam int unsigned CNT_W    = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam int unsigned TO_LOAD  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_WORDS - 1);

    cdce_state_t      state;
    logic             tail_sent;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_zero;
    logic             word_finished;

    // One shared timer: PWRUP runs from the reset value, the handshake and
    // gap phases reload on entry. PWRUP therefore spans POWERUP_CYCLES plus
    // the reset-release cycle.
    cdce_cfg_timer #(
        .WIDTH       (CNT_W),
        .RESET_VALUE (CNT_W'(POWERUP_CYCLES))
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (tmr_load),
        .value   (tmr_value),
        .zero    (tmr_zero)
    );

    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = '0;
        case (state)
            ST_ISSUE: begin
                tmr_load  = 1'b1;
                tmr_value = CNT_W'(TO_LOAD);
            end
            ST_WAIT_ACK: begin
                if (!ser_done) begin
                    tmr_load  = 1'b1;
                    tmr_value = CNT_W'(TO_LOAD);
                end
            end
            ST_WAIT_DONE: begin
                if (ser_done) begin
                    tmr_load  = 1'b1;
                    tmr_value = CNT_W'(GAP_LOAD);
                end
            end
            default: ;
        endcase
    end

    // A zero-length gap finishes the word straight out of WAIT_DONE.
    assign word_finished = ((state == ST_WAIT_DONE) && ser_done && (GAP_CYCLES == 0)) ||
                           ((state == ST_GAP) && tmr_zero);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_PWRUP;
            word_addr   <= '0;
            ser_enable  <= 1'b0;
            ser_start   <= 1'b0;
            ser_data    <= '0;
            busy        <= 1'b0;
            config_done <= 1'b0;
            error       <= 1'b0;
            tail_sent   <= 1'b0;
        end else begin
            ser_enable <= 1'b1;
            case (state)
                ST_PWRUP: begin
                    if (POWERUP_CYCLES == 0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        busy <= 1'b1;
                        if (tmr_zero) begin
                            state     <= ST_FETCH;
                            word_addr <= '0;
                            tail_sent <= 1'b0;
                        end
                    end
                end
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state       <= ST_FETCH;
                        word_addr   <= '0;
                        config_done <= 1'b0;
                        error       <= 1'b0;
                        busy        <= 1'b1;
                        tail_sent   <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    ser_data  <= word_data;
                    ser_start <= 1'b1;
                    state     <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    state <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (!ser_done) begin
                        ser_start <= 1'b0;
                        state     <= ST_WAIT_DONE;
                    end else if (tmr_zero) begin
                        ser_start <= 1'b0;
                        error     <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_ERROR;
                    end
                end
                ST_WAIT_DONE: begin
                    if (ser_done) begin
                        if (GAP_CYCLES != 0) begin
                            state <= ST_GAP;
                        end
                    end else if (tmr_zero) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_ERROR;
                    end
                end
                ST_GAP: ;
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (word_finished) begin
                if (EEPROM_EN && !tail_sent && (word_addr == LAST_ADDR)) begin
                    tail_sent <= 1'b1;
                    ser_data  <= EEPROM_CMD;
                    ser_start <= 1'b1;
                    state     <= ST_ISSUE;
                end else if (tail_sent || (word_addr == LAST_ADDR)) begin
                    config_done <= 1'b1;
                    busy        <= 1'b0;
                    state       <= ST_DONE;
                end else begin
                    word_addr <= word_addr + AW'(1);
                    state     <= ST_FETCH;
                end
            end
        end
    end

endmodule

// File: tb/tb_cdce_config_sequencer.sv
// Directed bench: auto-start / reset-abort / stuck-busy on one instance,
// manual start / ack timeout on a second instance with auto-start disabled.
module tb_cdce_config_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

`ifdef CDCE_CFG_EEPROM_EN
    localparam int NTX = 4;
`else
    localparam int NTX = 3;
`endif

    // ---------------- instance A: auto-start ----------------
    logic        a_rst_n = 1'b0, a_start = 1'b0, a_done;
    logic [1:0]  a_addr;
    logic [31:0] a_wdata, a_sdata;
    logic        a_en, a_sstart, a_busy, a_cfg, a_err;
    logic [31:0] a_tbl [0:3];
    logic [31:0] a_log [0:15];
    int          a_n = 0, a_cnt = 0, a_mode = 0;

    assign a_wdata = a_tbl[a_addr];

    cdce_config_sequencer #(
        .NUM_WORDS(3), .POWERUP_CYCLES(10), .GAP_CYCLES(2), .TIMEOUT_CYCLES(40)
    ) dut_a (
        .clk(clk), .reset_n(a_rst_n), .start(a_start), .word_addr(a_addr),
        .word_data(a_wdata), .ser_enable(a_en), .ser_start(a_sstart),
        .ser_data(a_sdata), .ser_done(a_done), .busy(a_busy),
        .config_done(a_cfg), .error(a_err)
    );

    // mode 0 normal (done low 34 cycles), 1 never acks, 2 stays busy
    always @(posedge clk) begin
        if (!a_rst_n) begin
            a_done <= 1'b1;
            a_cnt  <= 0;
        end else if (a_done) begin
            if (a_sstart && a_mode != 1) begin
                a_done <= 1'b0;
                a_cnt  <= 33;
                if (a_n < 16) a_log[a_n] <= a_sdata;
                a_n <= a_n + 1;
            end
        end else if (a_mode != 2) begin
            if (a_cnt == 0) a_done <= 1'b1;
            else a_cnt <= a_cnt - 1;
        end
    end

    // ---------------- instance B: manual start ----------------
    logic        b_rst_n = 1'b0, b_start = 1'b0, b_done;
    logic [1:0]  b_addr;
    logic [31:0] b_wdata, b_sdata;
    logic        b_en, b_sstart, b_busy, b_cfg, b_err;
    logic [31:0] b_tbl [0:3];
    logic [31:0] b_log [0:15];
    logic [1:0]  b_alog [0:15];
    int          b_n = 0, b_cnt = 0, b_mode = 0;

    assign b_wdata = b_tbl[b_addr];

    cdce_config_sequencer #(
        .NUM_WORDS(3), .POWERUP_CYCLES(0), .GAP_CYCLES(2), .TIMEOUT_CYCLES(8)
    ) dut_b (
        .clk(clk), .reset_n(b_rst_n), .start(b_start), .word_addr(b_addr),
        .word_data(b_wdata), .ser_enable(b_en), .ser_start(b_sstart),
        .ser_data(b_sdata), .ser_done(b_done), .busy(b_busy),
        .config_done(b_cfg), .error(b_err)
    );

    always @(posedge clk) begin
        if (!b_rst_n) begin
            b_done <= 1'b1;
            b_cnt  <= 0;
        end else if (b_done) begin
            if (b_sstart && b_mode != 1) begin
                b_done <= 1'b0;
                b_cnt  <= 4;
                if (b_n < 16) begin
                    b_log[b_n]  <= b_sdata;
                    b_alog[b_n] <= b_addr;
                end
                b_n <= b_n + 1;
            end
        end else if (b_cnt == 0) begin
            b_done <= 1'b1;
        end else begin
            b_cnt <= b_cnt - 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc, base, hi, idle_starts;
        logic en1, busy1;

        a_tbl[0] = 32'hC0DE_0000; a_tbl[1] = 32'hC0DE_0001;
        a_tbl[2] = 32'hC0DE_0002; a_tbl[3] = 32'hDEAD_DEAD;
        b_tbl[0] = 32'h5A5A_0100; b_tbl[1] = 32'h5A5A_0101;
        b_tbl[2] = 32'h5A5A_0102; b_tbl[3] = 32'hDEAD_DEAD;

        // ---- A: reset values and auto-start latency ----
        repeat (3) tick();
        check("a_rst_addr",  32'(a_addr), 0);
        check("a_rst_start", 32'(a_sstart), 0);
        check("a_rst_data",  a_sdata, 0);
        check("a_rst_flags", {28'd0, a_en, a_busy, a_cfg, a_err}, 0);

        a_rst_n = 1'b1;
        cyc = 0; en1 = 1'b0; busy1 = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 1) begin en1 = a_en; busy1 = a_busy; end
            if (a_sstart) begin cyc = i; break; end
        end
        check("a_en_after_release", 32'(en1), 1);
        check("a_busy_pwrup", 32'(busy1), 1);
        check("a_first_start_cycle", cyc, 12);
        check("a_first_data", a_sdata, 32'hC0DE_0000);

        for (int i = 0; i < 600 && !a_cfg; i++) tick();
        check("a_cfg_done", 32'(a_cfg), 1);
        check("a_end_busy_err", {30'd0, a_busy, a_err}, 0);
        check("a_end_addr", 32'(a_addr), 2);
        check("a_tx_count", a_n, NTX);
        check("a_word0", a_log[0], 32'hC0DE_0000);
        check("a_word1", a_log[1], 32'hC0DE_0001);
        check("a_word2", a_log[2], 32'hC0DE_0002);
`ifdef CDCE_CFG_EEPROM_EN
        check("a_eeprom_cmd", a_log[3], 32'h0000_001F);
`endif
        repeat (5) tick();
        check("a_cfg_held", 32'(a_cfg), 1);

        // ---- A: restart from DONE, then reset during word 1 ----
        base = a_n;
        a_start = 1'b1; tick(); a_start = 1'b0;
        check("a_restart_clears", {30'd0, a_cfg, a_busy}, 1);
        for (int i = 0; i < 300 && a_n < base + 2; i++) tick();
        check("a_word1_issued", a_n, base + 2);
        repeat (5) tick();
        a_rst_n = 1'b0; tick();
        check("a_midrst_addr",  32'(a_addr), 0);
        check("a_midrst_data",  a_sdata, 0);
        check("a_midrst_flags", {27'd0, a_en, a_sstart, a_busy, a_cfg, a_err}, 0);
        a_rst_n = 1'b1;
        for (int i = 0; i < 40 && !a_sstart; i++) tick();
        check("a_rerun_start", 32'(a_sstart), 1);
        check("a_rerun_addr", 32'(a_addr), 0);
        for (int i = 0; i < 10 && a_n < base + 3; i++) tick();
        check("a_rerun_word0", a_log[base + 2], 32'hC0DE_0000);
        for (int i = 0; i < 600 && !a_cfg; i++) tick();
        check("a_rerun_done", 32'(a_cfg), 1);

        // ---- A: serializer stuck busy after ack ----
        a_mode = 2;
        base = a_n;
        a_start = 1'b1; tick(); a_start = 1'b0;
        cyc = 0;
        for (int i = 1; i <= 200 && !a_err; i++) begin tick(); cyc = i; end
        check("a_stuck_err", 32'(a_err), 1);
        check("a_stuck_flags", {29'd0, a_cfg, a_busy, a_sstart}, 0);
        check("a_stuck_tx", a_n, base + 1);
        // FETCH, ISSUE, one WAIT_ACK cycle, then 40 WAIT_DONE cycles
        check("a_stuck_cycles", cyc, 43);

        // ---- B: manual start ----
        b_rst_n = 1'b1;
        idle_starts = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (b_sstart || b_busy) idle_starts++;
        end
        check("b_idle_quiet", idle_starts, 0);
        check("b_idle_en", 32'(b_en), 1);
        base = b_n;
        b_start = 1'b1; tick(); b_start = 1'b0;
        check("b_fetch_busy", 32'(b_busy), 1);
        check("b_fetch_addr", 32'(b_addr), 0);
        tick();
        check("b_issue_start", 32'(b_sstart), 1);
        for (int i = 0; i < 300 && !b_cfg; i++) begin
            b_start = (i % 7 == 3);
            tick();
        end
        b_start = 1'b0;
        check("b_cfg_done", 32'(b_cfg), 1);
        check("b_tx_count", b_n - base, NTX);
        check("b_addr_seq", {26'd0, b_alog[base], b_alog[base+1], b_alog[base+2]}, 32'b00_01_10);
        check("b_word0", b_log[base],     32'h5A5A_0100);
        check("b_word2", b_log[base + 2], 32'h5A5A_0102);
        repeat (10) tick();
        check("b_no_restart", b_n - base, NTX);

        // ---- B: ack timeout ----
        b_mode = 1;
        b_start = 1'b1; tick(); b_start = 1'b0;
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (b_sstart) hi++;
            if (b_err) break;
        end
        check("b_to_start_cycles", hi, 9);
        check("b_to_err", 32'(b_err), 1);
        check("b_to_flags", {29'd0, b_sstart, b_busy, b_cfg}, 0);

        b_mode = 0;
        base = b_n;
        b_start = 1'b1; tick(); b_start = 1'b0;
        check("b_recover_flags", {30'd0, b_err, b_busy}, 1);
        for (int i = 0; i < 300 && !b_cfg; i++) tick();
        check("b_recover_done", {30'd0, b_cfg, b_err}, 2);
        check("b_recover_word0", b_log[base], 32'h5A5A_0100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
